fetch_realigner: RTL
====================

Name: fetch_realigner

Overview:
- Sits between the instruction cache and the IF stage. Takes the IF-stage PC and returns one aligned instruction with a compressed flag, which IF registers into its pipeline registers.
- Keeps a two-word fetch buffer in front of ICACHE. Handles RVC halfword alignment, including 32-bit instructions that straddle a word boundary.
- Optionally prefetches the next sequential word.

Parameters:
- BYTE_SWAP, 1: 1 = ICACHE_rdata byte lanes are reversed (rdata[31:24] is the byte at word offset 0) and are converted to little-endian packing on fill; 0 = no conversion.
- PREFETCH, 1: 1 = enable next-sequential-word prefetch when idle.
- NOP, 32'h00000013: value driven on inst when not ready.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc  in  32  IF-stage PC; pc[0] is ignored (always 0).
- ready  out  1  inst/compressed valid for the current pc, this cycle.
- compressed  out  1  current instruction is 16-bit.
- inst  out  32  aligned instruction; a 16-bit instruction is zero-extended.
- ICACHE_stall  in  1  cache busy; a request completes in a cycle where ren=1 and stall=0.
- ICACHE_ren  out  1  read request.
- ICACHE_wen  out  1  tied 0.
- ICACHE_addr  out  30  word address of the request.
- ICACHE_rdata  in  32  read data, valid in the completing cycle.
- ICACHE_wdata  out  32  tied 0.

Behaviour:
Storage:
- Two entries, E0 and E1. Each has valid, tag[29:0] (full word address) and data[31:0] (little-endian packed).
- A word with address W lives only in entry E[W[0]]. Words A and A+1 therefore always coexist.

Lookup (pure combinational on pc and entries):
- A = pc[31:2]. Halfword h = pc[1] ? E(A).data[31:16] : E(A).data[15:0].
- c = (h[1:0] != 2'b11).
- Needed words:
  - A only, if c or pc[1]==0.
  - A and A+1, if !c and pc[1]==1. A+1 is 30-bit wrap-around.
- ready = every needed word is a valid tag hit. When A itself misses, ready=0 (c is unknown).
- inst:
  - c: {16'h0, h}.
  - !c, pc[1]=0: E(A).data.
  - !c, pc[1]=1: {E(A+1).data[15:0], h}.
- When ready=0: inst=NOP, compressed=0.
- Latency: hit = 0 cycles. ready never depends combinationally on ICACHE_rdata.

FSM:
- States: IDLE, REQ.
- IDLE:
  - Demand target = first needed word that misses (A before A+1).
  - If a demand target exists: latch req_addr = target and go to REQ.
  - Else, if PREFETCH and ready and E(A+1) misses: latch req_addr = A+1 and go to REQ.
  - Else stay in IDLE.
- REQ:
  - ICACHE_ren=1; ICACHE_addr=req_addr, held constant.
  - On a cycle with ICACHE_stall=0: write rdata (swapped if BYTE_SWAP) into E[req_addr[0]], set valid and tag, go to IDLE.
- One outstanding request at a time. A demand miss arising during a prefetch waits for the prefetch to complete.
- Decision in IDLE is made on the same cycle. ren rises the cycle after the miss is seen, since it is driven from the state register.
- In IDLE: ren=0, ICACHE_addr=req_addr (last value).

Boundaries:
- pc changes during REQ (redirect/correction): the request is not aborted; the fill completes and the new pc is evaluated in IDLE next cycle.
- Fill on the same edge the pc needs it: ready=1 the following cycle.
- Straddle with both words missing: two sequential requests, A then A+1.
- ICACHE_stall while ren=0 is ignored.
- Reset (including mid-request):
  - Entries invalid, state IDLE, req_addr=0.
  - Outputs: ren=0, ready=0, inst=NOP, compressed=0. Outputs are forced asynchronously.
  - Any in-flight cache response is dropped.
- No invalidate path; the instruction memory is read-only.

Test Plan:
1. Cold start, straight hit:
   - Stimulus: rst pulse, pc=0. Cache returns rdata=32'h9300A000 after 2 stall cycles.
   - Required: ren=1 with addr=0 for 3 cycles; next cycle ready=1, inst=32'h00A00093, compressed=0.
2. Compressed pair in one word:
   - Stimulus: word 0 = 32'h45054501. pc=0, then pc=2.
   - Required: pc=0 → inst=32'h00004501, compressed=1. pc=2 → inst=32'h00004505, compressed=1, with no demand request.
3. Straddle:
   - Stimulus: PREFETCH=0. Word1 upper half = 16'h0093, word2 lower half = 16'h00A0. pc=6.
   - Required: requests addr=1 then addr=2; ready=1 only after both fills; inst=32'h00A00093.
4. Prefetch:
   - Stimulus: pc=0 hits, word 1 absent.
   - Required: next cycle ren=1 with addr=1 while ready stays 1.
   - Then pc=4 → 0-cycle hit.
5. Redirect mid-request:
   - Stimulus: addr=1 outstanding, pc jumps to 32'h100, stall held 3 cycles.
   - Required: addr stays 1 until completion; then ren with addr=30'h40; ready for 32'h100 one cycle after that fill.
6. Reset mid-request:
   - Stimulus: assert rst asynchronously during REQ.
   - Required: ren=0 and ready=0 before the next edge, inst=NOP. After release, pc=0 refetches addr=0.

Source files
------------

// File: rtl/fetch_realigner.sv
// fetch_realigner: two-entry fetch buffer in front of the instruction cache.
// Returns one RVC-aligned instruction per IF-stage PC, stitching 32-bit
// instructions that straddle a word boundary, and optionally prefetches the
// next sequential word while the current one is being consumed.
module fetch_realigner #(
  parameter bit          BYTE_SWAP = 1'b1,
  parameter bit          PREFETCH  = 1'b1,
  parameter logic [31:0] NOP       = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        compressed,
  output logic [31:0] inst,
  input  logic        ICACHE_stall,
  output logic        ICACHE_ren,
  output logic        ICACHE_wen,
  output logic [29:0] ICACHE_addr,
  input  logic [31:0] ICACHE_rdata,
  output logic [31:0] ICACHE_wdata
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [29:0] r_req_addr;
  logic [29:0] w_req_addr_nxt;
  logic        w_fill;

  // Entry E[k] only ever holds a word whose address has bit 0 == k
  logic [1:0]  r_valid;
  logic [29:0] r_tag  [2];
  logic [31:0] r_data [2];

  logic [29:0] w_a;
  logic [29:0] w_a1;
  logic        w_hit_a;
  logic        w_hit_a1;
  logic [31:0] w_word_a;
  logic [31:0] w_word_a1;
  logic [15:0] w_half;
  logic        w_c;
  logic        w_need_a1;
  logic        w_ready;
  logic [31:0] w_fill_data;
  logic        w_unused_pc0;

  // Reverse byte lanes so a big-lane cache word becomes little-endian packed
  function automatic logic [31:0] f_lane_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // pc[0] is architecturally always zero
  assign w_unused_pc0 = pc[0];

  assign w_a       = pc[31:2];
  assign w_a1      = w_a + 30'd1;
  assign w_hit_a   = r_valid[w_a[0]] && (r_tag[w_a[0]] == w_a);
  assign w_hit_a1  = r_valid[w_a1[0]] && (r_tag[w_a1[0]] == w_a1);
  assign w_word_a  = r_data[w_a[0]];
  assign w_word_a1 = r_data[w_a1[0]];
  assign w_half    = pc[1] ? w_word_a[31:16] : w_word_a[15:0];
  assign w_c       = (w_half[1:0] != 2'b11);
  // Only a 32-bit instruction starting in the upper half needs the next word
  assign w_need_a1 = !w_c && pc[1];
  // A miss on A makes the length unknown, so it alone forces not-ready
  assign w_ready   = w_hit_a && (!w_need_a1 || w_hit_a1);

  assign w_fill_data = BYTE_SWAP ? f_lane_swap(ICACHE_rdata) : ICACHE_rdata;

  // Aligned instruction output; NOP whenever the needed words are not all present
  always_comb begin
    ready      = w_ready;
    compressed = 1'b0;
    inst       = NOP;
    if (w_ready) begin
      compressed = w_c;
      if (w_c) begin
        inst = {16'h0000, w_half};
      end else if (pc[1]) begin
        inst = {w_word_a1[15:0], w_half};
      end else begin
        inst = w_word_a;
      end
    end
  end

  // Next-state: demand miss on A, then A+1, then optional prefetch of A+1
  always_comb begin
    w_state_nxt    = r_state;
    w_req_addr_nxt = r_req_addr;
    w_fill         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_hit_a) begin
          w_req_addr_nxt = w_a;
          w_state_nxt    = S_REQ;
        end else if (w_need_a1 && !w_hit_a1) begin
          w_req_addr_nxt = w_a1;
          w_state_nxt    = S_REQ;
        end else if (PREFETCH && w_ready && !w_hit_a1) begin
          w_req_addr_nxt = w_a1;
          w_state_nxt    = S_REQ;
        end
      end
      S_REQ: begin
        if (!ICACHE_stall) begin
          w_fill      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and request address; reset abandons any outstanding request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req_addr <= 30'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_addr <= w_req_addr_nxt;
    end
  end

  // Entry valid bits; the memory is read-only so entries are only ever filled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 2'b00;
    end else if (w_fill) begin
      r_valid[r_req_addr[0]] <= 1'b1;
    end
  end

  // Entry tag and data capture on the completing cache cycle
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[r_req_addr[0]]  <= r_req_addr;
      r_data[r_req_addr[0]] <= w_fill_data;
    end
  end

  assign ICACHE_ren   = (r_state == S_REQ);
  assign ICACHE_addr  = r_req_addr;
  assign ICACHE_wen   = 1'b0;
  assign ICACHE_wdata = 32'h00000000;

endmodule
